// File: rtl/rle_run_sequencer.sv
// Run-length sequencer: folds a word stream into (symbol, count, last) records behind a valid/ready slot.
// Optional RLE_STATS_EN adds wrapping word/record counters (stat_words, stat_runs).
module rle_run_sequencer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clock,
  input  logic              sysres,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_last,
`ifdef RLE_STATS_EN
  output logic [15:0]       stat_words,
  output logic [15:0]       stat_runs,
`endif
  output logic              busy
);

  localparam logic [CNT_W-1:0] MAXC = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   run_sym_q, run_sym_d;
  logic [CNT_W-1:0]    run_cnt_q, run_cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [CNT_W-1:0]    out_count_q, out_count_d;
  logic                out_last_q, out_last_d;

  logic                slot_free;
  logic                match;
  logic                rec_load;
  logic [CNT_W-1:0]    rec_count;
  logic                rec_last;

  assign slot_free = !out_valid_q || out_ready;
  assign match     = (in_data == run_sym_q) && (run_cnt_q < MAXC);

  // Run tracking, record generation and input acceptance
  always_comb begin
    state_d   = state_q;
    run_sym_d = run_sym_q;
    run_cnt_d = run_cnt_q;
    rec_load  = 1'b0;
    rec_count = run_cnt_q;
    rec_last  = 1'b0;
    in_ready  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          run_sym_d = in_data;
          run_cnt_d = ONE;
          state_d   = in_last ? FLUSH : RUN;
        end
      end
      RUN: begin
        in_ready = slot_free;
        if (in_valid && slot_free) begin
          if (match) begin
            if (in_last) begin
              rec_load  = 1'b1;
              rec_count = run_cnt_q + ONE;
              rec_last  = 1'b1;
              state_d   = IDLE;
            end else begin
              run_cnt_d = run_cnt_q + ONE;
            end
          end else begin
            // Symbol change or saturated run: close the old run, open a new one
            rec_load  = 1'b1;
            run_sym_d = in_data;
            run_cnt_d = ONE;
            state_d   = in_last ? FLUSH : RUN;
          end
        end
      end
      FLUSH: begin
        if (slot_free) begin
          rec_load = 1'b1;
          rec_last = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output slot: load wins over drain, otherwise hold while stalled
  always_comb begin
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_last_d  = out_last_q;
    if (rec_load) begin
      out_valid_d = 1'b1;
      out_data_d  = run_sym_q;
      out_count_d = rec_count;
      out_last_d  = rec_last;
    end
  end

  always_ff @(posedge clock or negedge sysres) begin
    if (!sysres) begin
      state_q     <= IDLE;
      run_sym_q   <= '0;
      run_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_sym_q   <= run_sym_d;
      run_cnt_q   <= run_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != IDLE) || out_valid_q;

`ifdef RLE_STATS_EN
  logic [15:0] stat_words_q, stat_words_d;
  logic [15:0] stat_runs_q, stat_runs_d;

  always_comb begin
    stat_words_d = stat_words_q;
    stat_runs_d  = stat_runs_q;
    if (in_valid && in_ready) stat_words_d = stat_words_q + 16'd1;
    if (out_valid_q && out_ready) stat_runs_d = stat_runs_q + 16'd1;
  end

  always_ff @(posedge clock or negedge sysres) begin
    if (!sysres) begin
      stat_words_q <= '0;
      stat_runs_q  <= '0;
    end else begin
      stat_words_q <= stat_words_d;
      stat_runs_q  <= stat_runs_d;
    end
  end

  assign stat_words = stat_words_q;
  assign stat_runs  = stat_runs_q;
`endif

endmodule

// File: tb/tb_rle_run_sequencer.sv
// Bench for rle_run_sequencer: randomized packets checked against a queue-based run-length model.
module tb_rle_run_sequencer;

  typedef struct packed {
    logic [31:0] d;
    logic [7:0]  c;
    logic        l;
  } rec_t;

  logic        clock = 1'b0;
  logic        sysres = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [7:0]  out_count;
  logic        out_last;
  logic        busy;
`ifdef RLE_STATS_EN
  logic [15:0] stat_words;
  logic [15:0] stat_runs;
`endif

  int checks = 0;
  int errors = 0;
  int stab_err = 0;
  bit rdy_hold = 1'b0;
  bit bp_rand = 1'b0;
  bit gap_en = 1'b0;

  logic [31:0] stim_d[$];
  bit          stim_l[$];
  rec_t        exp_q[$];
  rec_t        got_q[$];

  rle_run_sequencer dut (
    .clock    (clock),
    .sysres   (sysres),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_count(out_count),
    .out_last (out_last),
`ifdef RLE_STATS_EN
    .stat_words(stat_words),
    .stat_runs (stat_runs),
`endif
    .busy     (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    #1;
    if (rdy_hold) out_ready = 1'b0;
    else if (bp_rand) out_ready = 1'($urandom_range(0, 1));
    else out_ready = 1'b1;
  end

  // Capture handshaken records and watch that a stalled record stays put
  logic        pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [31:0] pd = '0;
  logic [7:0]  pc = '0;
  always @(negedge clock) begin
    if (pv && !pr && sysres) begin
      if (!(out_valid && out_data === pd && out_count === pc && out_last === pl)) stab_err++;
    end
    if (out_valid && out_ready && sysres) got_q.push_back('{d: out_data, c: out_count, l: out_last});
    pv = out_valid; pr = out_ready; pd = out_data; pc = out_count; pl = out_last;
  end

  // Reference: run-length encode each packet, splitting runs at 255
  function automatic void build_exp();
    bit          have;
    logic [31:0] sym;
    int          cnt;
    have = 1'b0; sym = '0; cnt = 0;
    exp_q.delete();
    foreach (stim_d[i]) begin
      if (have && stim_d[i] == sym && cnt < 255) begin
        cnt++;
      end else begin
        if (have) exp_q.push_back('{d: sym, c: 8'(cnt), l: 1'b0});
        sym = stim_d[i]; cnt = 1; have = 1'b1;
      end
      if (stim_l[i]) begin
        exp_q.push_back('{d: sym, c: 8'(cnt), l: 1'b1});
        have = 1'b0;
      end
    end
  endfunction

  task automatic send(input logic [31:0] d, input bit l, output bit to);
    int n;
    n = 0; to = 1'b0;
    in_valid = 1'b1; in_data = d; in_last = l;
    @(negedge clock);
    while (!in_ready && n < 300) begin
      n++;
      @(negedge clock);
    end
    if (!in_ready) to = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic drive_stim(output bit to);
    bit t;
    to = 1'b0;
    foreach (stim_d[i]) begin
      if (gap_en && $urandom_range(0, 3) == 0) begin
        @(posedge clock); #1;
      end
      send(stim_d[i], stim_l[i], t);
      if (t) to = 1'b1;
    end
  endtask

  task automatic wait_recs(input int n);
    int k;
    k = 0;
    while (got_q.size() < n && k < 3000) begin
      @(negedge clock);
      k++;
    end
    repeat (4) @(negedge clock);
  endtask

  task automatic add_word(input logic [31:0] d, input bit l);
    stim_d.push_back(d);
    stim_l.push_back(l);
  endtask

  task automatic do_reset();
    @(negedge clock);
    sysres = 1'b0;
    repeat (2) @(negedge clock);
    sysres = 1'b1;
    got_q.delete();
    stim_d.delete(); stim_l.delete();
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    bit to;
    #1;
    checks++;
    if ({out_valid, out_data, out_count, out_last, in_ready, busy} !== {1'b0, 32'd0, 8'd0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_init got v=%b d=%h c=%0d l=%b rdy=%b busy=%b exp 0/0/0/0/1/0",
               out_valid, out_data, out_count, out_last, in_ready, busy);
    end
    @(negedge clock); sysres = 1'b1;
    rdy_hold = 1'b1;
    @(posedge clock); #1;
    send(32'h11, 1'b0, to);
    send(32'h22, 1'b0, to);
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL reset_pre_valid got %b exp 1", out_valid);
    end
    sysres = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, busy, out_count} !== {1'b0, 1'b1, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL reset_async got v=%b rdy=%b busy=%b c=%0d exp v=0 rdy=1 busy=0 c=0", out_valid, in_ready, busy, out_count);
    end
    @(negedge clock);
    sysres = 1'b1; rdy_hold = 1'b0;
    got_q.delete(); stim_d.delete(); stim_l.delete();
    @(posedge clock); #1;
    add_word(32'hC0C0, 1'b0); add_word(32'hC0C0, 1'b1);
    build_exp();
    drive_stim(to);
    wait_recs(exp_q.size());
    checks++;
    if (got_q.size() != 1 || got_q[0] !== rec_t'({32'hC0C0, 8'd2, 1'b1})) begin
      errors++; $display("FAIL reset_next_pkt got n=%0d rec=%h exp n=1 rec=%h", got_q.size(), got_q[0], rec_t'({32'hC0C0, 8'd2, 1'b1}));
    end
  endtask

  task automatic test_basic();
    bit to;
    do_reset();
    add_word(32'hA, 1'b0); add_word(32'hA, 1'b0); add_word(32'hA, 1'b0); add_word(32'hB, 1'b1);
    build_exp();
    drive_stim(to);
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_flush_stall got %b exp 0", in_ready); end
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_flush_release got %b exp 1", in_ready); end
    wait_recs(exp_q.size());
    checks++;
    if (to !== 1'b0 || got_q.size() != 2) begin
      errors++; $display("FAIL basic_count got n=%0d to=%b exp n=2 to=0", got_q.size(), to);
    end
    foreach (exp_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_rec%0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy got %b exp 0", busy); end
`ifdef RLE_STATS_EN
    checks++;
    if (stat_words !== 16'd4 || stat_runs !== 16'd2) begin
      errors++; $display("FAIL stats_basic got words=%0d runs=%0d exp 4 2", stat_words, stat_runs);
    end
`endif
  endtask

  task automatic test_saturation();
    bit to;
    do_reset();
    for (int i = 1; i <= 300; i++) add_word(32'h5, i == 300);
    build_exp();
    drive_stim(to);
    wait_recs(exp_q.size());
    checks++;
    if (got_q.size() != 2 || to !== 1'b0) begin
      errors++; $display("FAIL sat_count got n=%0d to=%b exp n=2 to=0", got_q.size(), to);
    end
    checks++;
    if (got_q[0] !== rec_t'({32'h5, 8'd255, 1'b0})) begin
      errors++; $display("FAIL sat_rec0 got %h exp %h", got_q[0], rec_t'({32'h5, 8'd255, 1'b0}));
    end
    checks++;
    if (got_q[1] !== rec_t'({32'h5, 8'd45, 1'b1})) begin
      errors++; $display("FAIL sat_rec1 got %h exp %h", got_q[1], rec_t'({32'h5, 8'd45, 1'b1}));
    end
  endtask

  task automatic test_backpressure();
    bit to;
    int k;
    do_reset();
    stab_err = 0;
    rdy_hold = 1'b1;
    @(posedge clock); #1;
    add_word(32'hA, 1'b0); add_word(32'hB, 1'b0); add_word(32'hC, 1'b0); add_word(32'hD, 1'b1);
    build_exp();
    fork
      drive_stim(to);
      begin
        k = 0;
        @(negedge clock);
        while (!out_valid && k < 50) begin k++; @(negedge clock); end
        for (int c = 0; c < 5; c++) begin
          checks++;
          if ({in_ready, out_valid, out_data, out_count, out_last} !== {1'b0, 1'b1, 32'hA, 8'd1, 1'b0}) begin
            errors++;
            $display("FAIL bp_stall%0d got rdy=%b v=%b d=%h c=%0d l=%b exp rdy=0 v=1 d=a c=1 l=0",
                     c, in_ready, out_valid, out_data, out_count, out_last);
          end
          if (c < 4) @(negedge clock);
        end
        rdy_hold = 1'b0;
      end
    join
    wait_recs(exp_q.size());
    checks++;
    if (got_q.size() != 4 || to !== 1'b0) begin
      errors++; $display("FAIL bp_count got n=%0d to=%b exp n=4 to=0", got_q.size(), to);
    end
    foreach (exp_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_rec%0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    checks++;
    if (stab_err !== 0) begin errors++; $display("FAIL bp_stable got %0d exp 0", stab_err); end
  endtask

  task automatic test_back_to_back();
    bit to;
    do_reset();
    add_word(32'h77, 1'b1);
    add_word(32'hBEEF, 1'b0); add_word(32'hBEEF, 1'b1);
    add_word(32'hCAFE, 1'b1);
    build_exp();
    drive_stim(to);
    wait_recs(exp_q.size());
    checks++;
    if (got_q.size() != 3 || to !== 1'b0) begin
      errors++; $display("FAIL b2b_count got n=%0d to=%b exp n=3 to=0", got_q.size(), to);
    end
    foreach (exp_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_rec%0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    bit to;
    int len;
    do_reset();
    stab_err = 0;
    bp_rand = 1'b1; gap_en = 1'b1;
    for (int p = 0; p < 12; p++) begin
      len = $urandom_range(1, 14);
      for (int w = 0; w < len; w++) add_word(32'hD0D0_0000 + 32'($urandom_range(0, 2)), w == len - 1);
    end
    for (int w = 0; w < 262; w++) add_word(32'h1234_5678, 1'b0);
    add_word(32'h9, 1'b1);
    build_exp();
    drive_stim(to);
    wait_recs(exp_q.size());
    bp_rand = 1'b0; gap_en = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (got_q.size() != exp_q.size() || to !== 1'b0) begin
      errors++; $display("FAIL rand_count got n=%0d to=%b exp n=%0d to=0", got_q.size(), to, exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_rec%0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    checks++;
    if (stab_err !== 0) begin errors++; $display("FAIL rand_stable got %0d exp 0", stab_err); end
`ifdef RLE_STATS_EN
    checks++;
    if (stat_words !== 16'(stim_d.size()) || stat_runs !== 16'(exp_q.size())) begin
      errors++; $display("FAIL stats_rand got words=%0d runs=%0d exp %0d %0d", stat_words, stat_runs, stim_d.size(), exp_q.size());
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
